// File: rtl/rvc_compress_packer_if.sv
// rvc_compress_packer_if: instruction-in / packed-word-out
// valid/ready stream pair for the RVC compressor-packer.
interface rvc_compress_packer_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic        out_last;

    modport master (
        output in_valid, in_instr, in_last, out_ready,
        input  in_ready, out_valid, out_word, out_last
    );

    modport slave (
        input  in_valid, in_instr, in_last, out_ready,
        output in_ready, out_valid, out_word, out_last
    );
endinterface

// File: rtl/rvc_compress_packer.sv
// rvc_compress_packer: RV32I -> RV32C compressor with a
// little-endian 16/32-bit parcel packer and one output slot.
module rvc_compress_packer (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    input  logic                   compress_en,
    rvc_compress_packer_if.slave   bus,
    output logic [31:0]            stat_total,
    output logic [31:0]            stat_comp
);
    typedef enum logic [1:0] {EMPTY, HALF, FLUSH} state_t;

    state_t      state, state_nx;
    logic [15:0] held, held_nx;
    logic [31:0] i;
    logic [6:0]  op, f7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [11:0] imm_i, imm_s;
    logic [12:1] imm_b;
    logic [20:1] imm_j;
    logic        rdp, rs1p, rs2p, imm6;
    logic        addi, lw, sw, opr;
    logic        m_a4spn, m_a16sp, m_li, m_nop, m_addi, m_lui;
    logic        m_lw, m_sw, m_lwsp, m_swsp, m_jal, m_jalr, m_bz;
    logic        m_slli, m_sri, m_andi, m_mv, m_add, m_ca;
    logic [1:0]  ca_f2;
    logic [15:0] c16;
    logic        is16;
    logic        room, take, load, last_nx;
    logic [31:0] word_nx;
    logic        ov, ol;
    logic [31:0] ow;

    assign i     = bus.in_instr;
    assign op    = i[6:0];
    assign rd    = i[11:7];
    assign f3    = i[14:12];
    assign rs1   = i[19:15];
    assign rs2   = i[24:20];
    assign f7    = i[31:25];
    assign imm_i = i[31:20];
    assign imm_s = {i[31:25], i[11:7]};
    assign imm_b = {i[31], i[7], i[30:25], i[11:8]};
    assign imm_j = {i[31], i[19:12], i[20], i[30:21]};

    assign rdp  = rd[4:3] == 2'b01;
    assign rs1p = rs1[4:3] == 2'b01;
    assign rs2p = rs2[4:3] == 2'b01;
    // imm fits a signed 6-bit field when its top 7 bits agree
    assign imm6 = (&imm_i[11:5]) | ~(|imm_i[11:5]);

    assign addi = op == 7'h13 && f3 == 3'd0;
    assign lw   = op == 7'h03 && f3 == 3'd2;
    assign sw   = op == 7'h23 && f3 == 3'd2;
    assign opr  = op == 7'h33;

    assign m_a4spn = addi && rdp && rs1 == 5'd2
                  && imm_i[11:10] == 2'b00
                  && imm_i[1:0] == 2'b00 && |imm_i[9:2];
    assign m_a16sp = addi && rd == 5'd2 && rs1 == 5'd2
                  && imm_i[3:0] == 4'h0 && |imm_i
                  && ((&imm_i[11:9]) | ~(|imm_i[11:9]));
    assign m_li    = addi && rd != 5'd0 && rs1 == 5'd0 && imm6;
    assign m_nop   = addi && rd == 5'd0 && rs1 == 5'd0
                  && imm_i == 12'h000;
    assign m_addi  = addi && rd == rs1 && rd != 5'd0
                  && imm_i != 12'h000 && imm6;
    assign m_lui   = op == 7'h37 && rd != 5'd0 && rd != 5'd2
                  && |i[31:12]
                  && ((&i[31:17]) | ~(|i[31:17]));
    assign m_lw    = lw && rdp && rs1p
                  && imm_i[11:7] == 5'd0 && imm_i[1:0] == 2'b00;
    assign m_sw    = sw && rs2p && rs1p
                  && imm_s[11:7] == 5'd0 && imm_s[1:0] == 2'b00;
    assign m_lwsp  = lw && rd != 5'd0 && rs1 == 5'd2
                  && imm_i[11:8] == 4'd0 && imm_i[1:0] == 2'b00;
    assign m_swsp  = sw && rs1 == 5'd2
                  && imm_s[11:8] == 4'd0 && imm_s[1:0] == 2'b00;
    assign m_jal   = op == 7'h6f && rd[4:1] == 4'd0
                  && ((&imm_j[20:11]) | ~(|imm_j[20:11]));
    assign m_jalr  = op == 7'h67 && f3 == 3'd0 && rd[4:1] == 4'd0
                  && rs1 != 5'd0 && imm_i == 12'h000;
    assign m_bz    = op == 7'h63 && f3[2:1] == 2'b00 && rs1p
                  && rs2 == 5'd0
                  && ((&imm_b[12:8]) | ~(|imm_b[12:8]));
    assign m_slli  = op == 7'h13 && f3 == 3'd1 && f7 == 7'h00
                  && rd == rs1 && rd != 5'd0 && rs2 != 5'd0;
    assign m_sri   = op == 7'h13 && f3 == 3'd5
                  && (f7 == 7'h00 || f7 == 7'h20)
                  && rd == rs1 && rdp && rs2 != 5'd0;
    assign m_andi  = op == 7'h13 && f3 == 3'd7 && rd == rs1
                  && rdp && imm6;
    assign m_mv    = opr && f3 == 3'd0 && f7 == 7'h00
                  && rd != 5'd0 && rs1 == 5'd0 && rs2 != 5'd0;
    assign m_add   = opr && f3 == 3'd0 && f7 == 7'h00
                  && rd == rs1 && rd != 5'd0 && rs2 != 5'd0;
    assign m_ca    = opr && rd == rs1 && rdp && rs2p
                  && ((f7 == 7'h20 && f3 == 3'd0)
                   || (f7 == 7'h00 && (f3 == 3'd4 || f3 == 3'd6
                                    || f3 == 3'd7)));
    assign ca_f2   = (f3 == 3'd0) ? 2'b00 :
                     (f3 == 3'd4) ? 2'b01 :
                     (f3 == 3'd6) ? 2'b10 : 2'b11;

    // Compressor: first matching rule in priority order wins
    always_comb begin
        c16  = 16'h0000;
        is16 = 1'b0;
        if (compress_en && i[1:0] == 2'b11) begin
            is16 = 1'b1;
            priority case (1'b1)
                m_a4spn: c16 = {3'b000, imm_i[5:4], imm_i[9:6],
                                imm_i[2], imm_i[3], rd[2:0], 2'b00};
                m_a16sp: c16 = {3'b011, imm_i[9], 5'd2, imm_i[4],
                                imm_i[6], imm_i[8:7], imm_i[5], 2'b01};
                m_li:    c16 = {3'b010, imm_i[5], rd, imm_i[4:0], 2'b01};
                m_nop:   c16 = 16'h0001;
                m_addi:  c16 = {3'b000, imm_i[5], rd, imm_i[4:0], 2'b01};
                m_lui:   c16 = {3'b011, i[17], rd, i[16:12], 2'b01};
                m_lw:    c16 = {3'b010, imm_i[5:3], rs1[2:0], imm_i[2],
                                imm_i[6], rd[2:0], 2'b00};
                m_sw:    c16 = {3'b110, imm_s[5:3], rs1[2:0], imm_s[2],
                                imm_s[6], rs2[2:0], 2'b00};
                m_lwsp:  c16 = {3'b010, imm_i[5], rd, imm_i[4:2],
                                imm_i[7:6], 2'b10};
                m_swsp:  c16 = {3'b110, imm_s[5:2], imm_s[7:6], rs2, 2'b10};
                m_jal:   c16 = {~rd[0], 2'b01, imm_j[11], imm_j[4],
                                imm_j[9:8], imm_j[10], imm_j[6], imm_j[7],
                                imm_j[3:1], imm_j[5], 2'b01};
                m_jalr:  c16 = {3'b100, rd[0], rs1, 5'd0, 2'b10};
                m_bz:    c16 = {2'b11, f3[0], imm_b[8], imm_b[4:3],
                                rs1[2:0], imm_b[7:6], imm_b[2:1],
                                imm_b[5], 2'b01};
                m_slli:  c16 = {4'b0000, rd, rs2, 2'b10};
                m_sri:   c16 = {5'b10000, f7[5], rd[2:0], rs2, 2'b01};
                m_andi:  c16 = {3'b100, imm_i[5], 2'b10, rd[2:0],
                                imm_i[4:0], 2'b01};
                m_mv:    c16 = {4'b1000, rd, rs2, 2'b10};
                m_add:   c16 = {4'b1001, rd, rs2, 2'b10};
                m_ca:    c16 = {6'b100011, rd[2:0], ca_f2, rs2[2:0],
                                2'b01};
                default: is16 = 1'b0;
            endcase
        end
    end

    assign room         = !ov || bus.out_ready;
    assign bus.in_ready = (state != FLUSH) && room;
    assign take         = bus.in_valid && bus.in_ready;

    // Packer next state: places parcels, decides when a word is complete
    always_comb begin
        state_nx = state;
        held_nx  = held;
        load     = 1'b0;
        word_nx  = 32'h0;
        last_nx  = 1'b0;
        unique case (state)
            EMPTY: if (take) begin
                if (is16) begin
                    if (bus.in_last) begin
                        load    = 1'b1;
                        word_nx = {16'h0001, c16};
                        last_nx = 1'b1;
                    end else begin
                        held_nx  = c16;
                        state_nx = HALF;
                    end
                end else begin
                    load    = 1'b1;
                    word_nx = i;
                    last_nx = bus.in_last;
                end
            end
            HALF: if (take) begin
                load = 1'b1;
                if (is16) begin
                    word_nx  = {c16, held};
                    last_nx  = bus.in_last;
                    state_nx = EMPTY;
                end else begin
                    word_nx  = {i[15:0], held};
                    held_nx  = i[31:16];
                    state_nx = bus.in_last ? FLUSH : HALF;
                end
            end
            FLUSH: if (room) begin
                load     = 1'b1;
                word_nx  = {16'h0001, held};
                last_nx  = 1'b1;
                state_nx = EMPTY;
            end
            default: state_nx = EMPTY;
        endcase
    end

    // Packer state and held upper/lower parcel
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= EMPTY;
            held  <= 16'h0;
        end else begin
            state <= state_nx;
            held  <= held_nx;
        end
    end

    // Single-entry output slot, held stable while stalled
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            ov <= 1'b0;
            ow <= 32'h0;
            ol <= 1'b0;
        end else if (load) begin
            ov <= 1'b1;
            ow <= word_nx;
            ol <= last_nx;
        end else if (bus.out_ready) begin
            ov <= 1'b0;
        end
    end

    assign bus.out_valid = ov;
    assign bus.out_word  = ow;
    assign bus.out_last  = ol;

    // Accepted / compressed instruction counters
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            stat_total <= 32'h0;
            stat_comp  <= 32'h0;
        end else if (take) begin
            stat_total <= stat_total + 32'd1;
            if (is16) stat_comp <= stat_comp + 32'd1;
        end
    end
endmodule

// File: tb/tb_rvc_compress_packer.sv
// tb_rvc_compress_packer: random and directed stimulus checked
// against a parcel-queue reference model of the packer.
module tb_rvc_compress_packer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b1;
    logic [31:0] stat_total, stat_comp;

    rvc_compress_packer_if bus ();

    rvc_compress_packer dut (
        .clk_in      (clk),
        .rst_n_in    (rst_n),
        .compress_en (en),
        .bus         (bus),
        .stat_total  (stat_total),
        .stat_comp   (stat_comp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ins;
        bit          last;
        bit          en;
    } stim_t;

    typedef struct {
        logic [31:0] w;
        bit          l;
    } exp_t;

    stim_t       stim[$];
    exp_t        eq[$];
    logic [15:0] pq[$];
    int          m_total, m_comp;
    int          n_chk, n_err;
    logic [31:0] last_out;
    logic        last_lst;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit rp(input int r);
        return r >= 8 && r <= 15;
    endfunction

    function automatic bit sm(input int v);
        return v >= -32 && v <= 31;
    endfunction

    // Reference compressor: {is16, parcel}
    function automatic logic [16:0] ref_c(input logic [31:0] x,
                                          input bit e);
        int op, rd, f3, rs1, rs2, f7, ii, is, ib, ij, u;
        op  = int'(x[6:0]);
        rd  = int'(x[11:7]);
        f3  = int'(x[14:12]);
        rs1 = int'(x[19:15]);
        rs2 = int'(x[24:20]);
        f7  = int'(x[31:25]);
        ii  = int'($signed(x[31:20]));
        is  = int'($signed({x[31:25], x[11:7]}));
        ib  = int'($signed({x[31], x[7], x[30:25], x[11:8], 1'b0}));
        ij  = int'($signed({x[31], x[19:12], x[20], x[30:21], 1'b0}));
        u   = int'($signed(x[31:12]));
        if (!e || x[1:0] != 2'b11) return 17'h0;
        if (op == 'h13 && f3 == 0) begin
            if (rp(rd) && rs1 == 2 && ii >= 4 && ii <= 1020
                && ii % 4 == 0)
                return {1'b1, 3'b000, ii[5:4], ii[9:6], ii[2], ii[3],
                        3'(rd - 8), 2'b00};
            if (rd == 2 && rs1 == 2 && ii % 16 == 0 && ii >= -512
                && ii <= 496 && ii != 0)
                return {1'b1, 3'b011, ii[9], 5'd2, ii[4], ii[6],
                        ii[8:7], ii[5], 2'b01};
            if (rd != 0 && rs1 == 0 && sm(ii))
                return {1'b1, 3'b010, ii[5], 5'(rd), ii[4:0], 2'b01};
            if (rd == 0 && rs1 == 0 && ii == 0) return 17'h10001;
            if (rd == rs1 && rd != 0 && ii != 0 && sm(ii))
                return {1'b1, 3'b000, ii[5], 5'(rd), ii[4:0], 2'b01};
        end
        if (op == 'h13 && f3 == 1 && f7 == 0 && rd == rs1 && rd != 0
            && rs2 != 0)
            return {1'b1, 4'b0000, 5'(rd), 5'(rs2), 2'b10};
        if (op == 'h13 && f3 == 5 && (f7 == 0 || f7 == 32)
            && rd == rs1 && rp(rd) && rs2 != 0)
            return {1'b1, 5'b10000, f7 == 32, 3'(rd - 8), 5'(rs2),
                    2'b01};
        if (op == 'h13 && f3 == 7 && rd == rs1 && rp(rd) && sm(ii))
            return {1'b1, 3'b100, ii[5], 2'b10, 3'(rd - 8), ii[4:0],
                    2'b01};
        if (op == 'h37 && rd != 0 && rd != 2 && u != 0 && sm(u))
            return {1'b1, 3'b011, u[5], 5'(rd), u[4:0], 2'b01};
        if (op == 'h03 && f3 == 2) begin
            if (rp(rd) && rp(rs1) && ii >= 0 && ii <= 124 && ii % 4 == 0)
                return {1'b1, 3'b010, ii[5:3], 3'(rs1 - 8), ii[2], ii[6],
                        3'(rd - 8), 2'b00};
            if (rd != 0 && rs1 == 2 && ii >= 0 && ii <= 252
                && ii % 4 == 0)
                return {1'b1, 3'b010, ii[5], 5'(rd), ii[4:2], ii[7:6],
                        2'b10};
        end
        if (op == 'h23 && f3 == 2) begin
            if (rp(rs2) && rp(rs1) && is >= 0 && is <= 124 && is % 4 == 0)
                return {1'b1, 3'b110, is[5:3], 3'(rs1 - 8), is[2], is[6],
                        3'(rs2 - 8), 2'b00};
            if (rs1 == 2 && is >= 0 && is <= 252 && is % 4 == 0)
                return {1'b1, 3'b110, is[5:2], is[7:6], 5'(rs2), 2'b10};
        end
        if (op == 'h6f && rd <= 1 && ij >= -2048 && ij <= 2046)
            return {1'b1, (rd == 1) ? 3'b001 : 3'b101, ij[11], ij[4],
                    ij[9:8], ij[10], ij[6], ij[7], ij[3:1], ij[5], 2'b01};
        if (op == 'h67 && f3 == 0 && rd <= 1 && rs1 != 0 && ii == 0)
            return {1'b1, 3'b100, rd == 1, 5'(rs1), 5'd0, 2'b10};
        if (op == 'h63 && f3 <= 1 && rp(rs1) && rs2 == 0 && ib >= -256
            && ib <= 254)
            return {1'b1, 2'b11, f3 == 1, ib[8], ib[4:3], 3'(rs1 - 8),
                    ib[7:6], ib[2:1], ib[5], 2'b01};
        if (op == 'h33) begin
            if (f3 == 0 && f7 == 0 && rd != 0 && rs1 == 0 && rs2 != 0)
                return {1'b1, 4'b1000, 5'(rd), 5'(rs2), 2'b10};
            if (f3 == 0 && f7 == 0 && rd == rs1 && rd != 0 && rs2 != 0)
                return {1'b1, 4'b1001, 5'(rd), 5'(rs2), 2'b10};
            if (rd == rs1 && rp(rd) && rp(rs2)) begin
                if (f3 == 0 && f7 == 32)
                    return {1'b1, 6'b100011, 3'(rd - 8), 2'd0,
                            3'(rs2 - 8), 2'b01};
                if (f7 == 0 && (f3 == 4 || f3 == 6 || f3 == 7))
                    return {1'b1, 6'b100011, 3'(rd - 8),
                            (f3 == 4) ? 2'd1 : (f3 == 6) ? 2'd2 : 2'd3,
                            3'(rs2 - 8), 2'b01};
            end
        end
        return 17'h0;
    endfunction

    // Reference packer: stream of 16-bit parcels cut into words
    task automatic m_accept(input logic [31:0] ins, input bit last,
                            input bit e);
        logic [16:0] r;
        exp_t        x;
        r = ref_c(ins, e);
        m_total++;
        if (r[16]) begin
            m_comp++;
            pq.push_back(r[15:0]);
        end else begin
            pq.push_back(ins[15:0]);
            pq.push_back(ins[31:16]);
        end
        if (last && pq.size() % 2 == 1) pq.push_back(16'h0001);
        while (pq.size() >= 2) begin
            x.w = {pq[1], pq[0]};
            void'(pq.pop_front());
            void'(pq.pop_front());
            x.l = last && pq.size() == 0;
            eq.push_back(x);
        end
    endtask

    function automatic logic [4:0] pick_reg();
        case ($urandom_range(0, 5))
            0:       return 5'd0;
            1:       return 5'd2;
            2:       return 5'($urandom_range(0, 31));
            default: return 5'($urandom_range(8, 15));
        endcase
    endfunction

    function automatic int pick_imm();
        int b[20] = '{0, 4, 16, 31, 32, -32, -33, 124, 128, 252, 256,
                      496, 512, -512, 1020, 1024, 2046, -2048, 254, -258};
        if ($urandom_range(0, 2) == 0)
            return int'($urandom_range(0, 4095)) - 2048;
        return b[$urandom_range(0, 19)] + 4 * int'($urandom_range(0, 1));
    endfunction

    function automatic logic [31:0] gen();
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        int          m;
        logic [31:0] v;
        rd  = pick_reg();
        rs1 = ($urandom_range(0, 1) == 0) ? rd : pick_reg();
        rs2 = pick_reg();
        m   = pick_imm();
        v   = m;
        f3  = 3'($urandom_range(0, 7));
        f7  = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20;
        case ($urandom_range(0, 11))
            0, 1: return {v[11:0], rs1, 3'd0, rd, 7'h13};
            2:  return {v[19:0], rd, 7'h37};
            3:  return {v[11:0], rs1, 3'd2, rd, 7'h03};
            4:  return {v[11:5], rs2, rs1, 3'd2, v[4:0], 7'h23};
            5:  return {v[20], v[10:1], v[11], v[19:12], rd, 7'h6f};
            6:  return {($urandom_range(0, 1) == 0) ? 12'h0 : v[11:0],
                        rs1, 3'd0, rd, 7'h67};
            7:  return {v[12], v[10:5], rs2, rs1, 3'($urandom_range(0, 1)),
                        v[4:1], v[11], 7'h63};
            8:  return {f7, v[4:0], rs1, ($urandom_range(0, 1) == 0)
                        ? 3'd1 : 3'd5, rd, 7'h13};
            9:  return {v[11:0], rs1, 3'd7, rd, 7'h13};
            10: return {f7, rs2, rs1, f3, rd, 7'h33};
            default: return $urandom;
        endcase
    endfunction

    task automatic cycle(input int idle_pct, input int rdy_pct);
        @(negedge clk);
        if (stim.size() > 0 && $urandom_range(0, 99) >= idle_pct) begin
            bus.in_valid = 1'b1;
            bus.in_instr = stim[0].ins;
            bus.in_last  = stim[0].last;
            en           = stim[0].en;
        end else begin
            bus.in_valid = 1'b0;
            bus.in_instr = $urandom;
            bus.in_last  = 1'($urandom_range(0, 1));
        end
        bus.out_ready = $urandom_range(0, 99) < rdy_pct;
        #1;
        chk("stat_total", stat_total, m_total);
        chk("stat_comp", stat_comp, m_comp);
        chk("out_valid", 32'(bus.out_valid), 32'(eq.size() != 0));
        chk("in_ready", 32'(bus.in_ready), 32'(eq.size() == 0
            || (eq.size() == 1 && bus.out_ready)));
        if (bus.out_valid && eq.size() > 0) begin
            chk("out_word", bus.out_word, eq[0].w);
            chk("out_last", 32'(bus.out_last), 32'(eq[0].l));
            if (bus.out_ready) begin
                last_out = bus.out_word;
                last_lst = bus.out_last;
                void'(eq.pop_front());
            end
        end
        if (bus.in_valid && bus.in_ready) begin
            m_accept(stim[0].ins, stim[0].last, stim[0].en);
            void'(stim.pop_front());
        end
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 200; k++) begin
            if (stim.size() == 0 && eq.size() == 0) break;
            cycle(0, 100);
        end
        chk(tag, stim.size() + eq.size(), 0);
    endtask

    task automatic put(input logic [31:0] ins, input bit last,
                       input bit e);
        stim_t s;
        s.ins  = ins;
        s.last = last;
        s.en   = e;
        stim.push_back(s);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_ovalid"}, 32'(bus.out_valid), 0);
        chk({tag, "_oword"}, bus.out_word, 0);
        chk({tag, "_olast"}, 32'(bus.out_last), 0);
        chk({tag, "_total"}, stat_total, 0);
        chk({tag, "_comp"}, stat_comp, 0);
        chk({tag, "_iready"}, 32'(bus.in_ready), 1);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_instr  = 32'h0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        n_chk = 0;
        n_err = 0;
        m_total = 0;
        m_comp = 0;
        last_out = 32'h0;
        last_lst = 1'b0;
        #12;
        check_reset("reset");
        @(negedge clk);
        rst_n = 1'b1;

        chk("ref_a4spn", 32'(ref_c(32'h01010413, 1'b1)), 32'h10800);
        chk("ref_addi31", 32'(ref_c(32'h01F48493, 1'b1)), 32'h104FD);
        chk("ref_addi32", 32'(ref_c(32'h02048493, 1'b1)), 32'h0);
        chk("ref_lui", 32'(ref_c(32'h123452B7, 1'b1)), 32'h0);
        chk("ref_nop", 32'(ref_c(32'h00000013, 1'b1)), 32'h10001);

        put(32'h01010413, 0, 1);
        put(32'h01010413, 0, 1);
        drain("drain_a4spn");
        chk("tp_a4spn", last_out, 32'h08000800);
        chk("tp_a4spn_comp", stat_comp, 2);

        put(32'h123452B7, 0, 1);
        drain("drain_lui");
        chk("tp_lui", last_out, 32'h123452B7);
        chk("tp_lui_comp", stat_comp, 2);

        put(32'h00000013, 0, 1);
        put(32'h123452B7, 1, 1);
        drain("drain_flush");
        chk("tp_flush", last_out, 32'h00011234);
        chk("tp_flush_last", 32'(last_lst), 1);

        put(32'h01F48493, 0, 1);
        put(32'h02048493, 1, 1);
        drain("drain_addi");
        chk("tp_addi", last_out, 32'h00010204);

        put(32'h89ABCDEF, 0, 1);
        put(32'h00000013, 1, 0);
        cycle(0, 0);
        for (int k = 0; k < 3; k++) cycle(0, 0);
        chk("tp_stall_pend", stim.size(), 1);
        drain("drain_stall");
        chk("tp_raw_nop", last_out, 32'h00000013);

        for (int k = 0; k < 3000; k++) begin
            if (stim.size() < 2)
                put(gen(), $urandom_range(0, 9) == 0,
                    $urandom_range(0, 4) != 0);
            cycle(25, 70);
        end
        put(gen(), 1, 1);
        drain("drain_random");

        put(32'h01F48493, 0, 1);
        drain("drain_half");
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset("midreset");
        pq.delete();
        eq.delete();
        m_total = 0;
        m_comp = 0;
        @(negedge clk);
        rst_n = 1'b1;
        put(32'h123452B7, 0, 1);
        drain("drain_after_rst");
        chk("tp_no_held", last_out, 32'h123452B7);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end
endmodule
